imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered, parametrised immediate generator that sits between instruction fetch and the decode/ALU operand mux. Accepts one 32-bit instruction per cycle through a valid/ready handshake and produces the sign-extended immediate, an immediate-format code, and an illegal-opcode flag. A two-entry skid buffer gives full throughput with a registered `in_ready`. The block supports XLEN of 32 or 64 and a flush for branch redirect.

## Interface
- `XLEN`, 32: datapath width. Legal values are 32 and 64. The immediate and the PC tag are this width.
- `CNT_W`, 16: width of the saturating illegal-instruction counter.
- `clk` in 1: single clock. All state is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous. Drops all buffered entries.
- `in_valid` in 1: an instruction is offered.
- `in_ready` out 1: the block can accept. Equal to `!skid_valid`.
- `in_inst` in 32: raw instruction.
- `in_pc` in XLEN: PC tag, passed through unchanged.
- `out_valid` out 1: the output entry is valid.
- `out_ready` in 1: the consumer accepts.
- `out_imm` out XLEN: sign-extended immediate.
- `out_fmt` out 3: 0=I, 1=S, 2=B, 3=U, 4=J, 5=NONE, 6=Z (CSR zimm).
- `out_illegal` out 1: the opcode is unrecognised, or `inst[1:0] != 2'b11`.
- `out_inst` out 32: the instruction, passed through.
- `out_pc` out XLEN: the PC, passed through.
- `illegal_cnt` out CNT_W: count of illegal instructions that completed an output handshake.

## Operation
Decode is on `inst[6:2]`. Every immediate is sign-extended from `inst[31]` to XLEN.
- LOAD 00000, ARITH_I 00100, JALR 11001 → I: `inst[31:20]`.
- OP-IMM-32 00110 → I when XLEN=64. Illegal when XLEN=32.
- STORE 01000 → S: `{inst[31:25], inst[11:7]}`.
- BRANCH 11000 → B: `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`.
- LUI 01101, AUIPC 00101 → U: `{inst[31:12], 12'b0}`.
- JAL 11011 → J: `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`.
- ARITH_R 01100, OP-32 01110 (XLEN=64 only) → NONE, imm = 0.
- SYSTEM 11100 → see Configuration.
- Any other opcode, or `inst[1:0] != 11` → illegal=1, fmt=NONE, imm=0.
- Shifts use the plain I immediate. The shamt is not reinterpreted here.

Skid buffer: an output register plus one skid register.
- Accept when `in_valid && in_ready`.
- If the output register is empty or is draining this cycle, the decoded entry loads the output register. Otherwise it loads the skid register.
- When the output drains, the skid entry moves to the output register.
- Decode happens before registering. The skid register holds already-decoded fields.

`illegal_cnt` increments on `out_valid && out_ready && out_illegal` and saturates at all-ones. `flush` does not clear it.

## Timing
- Latency: 1 cycle from an accepted input to `out_valid`.
- Throughput: 1 per cycle while `out_ready` stays high.
- Reset values: `out_valid`=0, skid empty, `in_ready`=1, `out_imm`/`out_inst`/`out_pc`=0, `out_fmt`=5, `out_illegal`=0, `illegal_cnt`=0.
- Reset asserted mid-transfer discards both entries immediately.
- `flush` takes priority over accept: both entries invalidate and a same-cycle input is dropped. `in_ready`=1 on the next cycle. An output handshake in the flush cycle still counts toward `illegal_cnt`.
- Full state (both entries valid): `in_ready`=0. A drain frees the skid on the next edge.
- Simultaneous accept and drain with the skid empty: the new entry replaces the output register. No bubble.
- `out_*` data is stable while `out_valid && !out_ready`.

## Configuration
`IMMGEN_CSR_ZIMM_EN` controls SYSTEM decode.
- Defined: SYSTEM with funct3[2]=1 (CSRRWI/SI/CI) → fmt Z, imm = zero-extended `inst[19:15]`. Other SYSTEM → fmt I (CSR address in `inst[31:20]`, sign-extended).
- Undefined: SYSTEM → fmt NONE, imm 0, not illegal.

## Structure
- Shared package `riscv_pkg`: opcode constants (`OPCODE_*`, including OP_IMM_32 and OP_32) and the `imm_fmt_e` encoding.
- Sub-module `imm_decode`: purely combinational. Maps `inst` to imm/fmt/illegal and is parameterised by XLEN. The top holds the skid buffer, the flush logic and the counter.

## Test plan
- XLEN=32, `addi x1,x0,-1` (0xFFF00093), `out_ready`=1 → next cycle imm=0xFFFFFFFF, fmt=0.
- XLEN=64, `beq` with offset −4 (0xFE000EE3) → imm=0xFFFFFFFFFFFFFFFC, fmt=2. `lui` 0x80000037 → imm=0xFFFFFFFF80000000.
- Stream of 4 instructions, `out_ready` low for 2 cycles → `in_ready` drops after 2 accepts. No loss, no duplication, order preserved.
- `flush` while both entries are full and `in_valid`=1 → `out_valid`=0 next cycle, `in_ready`=1, input dropped.
- 0x00000000 (inst[1:0]=00) handshaken 3 times → `out_illegal`=1 each time, `illegal_cnt`=3. With CNT_W=2, 5 illegals → `illegal_cnt` saturates at 3.
- `csrrwi` 0x7C1FD073 (zimm=31): with the macro → fmt 6, imm=31. Without the macro → fmt 5, imm=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: major opcodes (inst[6:2]) and the immediate-format code.
package riscv_pkg;

    localparam logic [4:0] OPCODE_LOAD      = 5'b00000;
    localparam logic [4:0] OPCODE_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC     = 5'b00101;
    localparam logic [4:0] OPCODE_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPCODE_STORE     = 5'b01000;
    localparam logic [4:0] OPCODE_OP        = 5'b01100;
    localparam logic [4:0] OPCODE_LUI       = 5'b01101;
    localparam logic [4:0] OPCODE_OP_32     = 5'b01110;
    localparam logic [4:0] OPCODE_BRANCH    = 5'b11000;
    localparam logic [4:0] OPCODE_JALR      = 5'b11001;
    localparam logic [4:0] OPCODE_JAL       = 5'b11011;
    localparam logic [4:0] OPCODE_SYSTEM    = 5'b11100;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / decoded-immediate-out stream bundle for imm_gen_pipe.
interface imm_gen_pipe_if #(parameter int XLEN = 32);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst, out_pc
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst, out_pc
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate decoder. Optional macro IMMGEN_CSR_ZIMM_EN enables
// CSR zimm / CSR-address decode of SYSTEM instructions.
module imm_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (inst[6:2])
            OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_JALR: begin
                fmt   = FMT_I;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OPCODE_OP_IMM_32: begin
                if (XLEN == 64) begin
                    fmt   = FMT_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end else begin
                    illegal = 1'b1;
                end
            end
            OPCODE_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPCODE_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPCODE_LUI, OPCODE_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {inst[31:12], 12'b0};
            end
            OPCODE_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPCODE_OP: ;
            OPCODE_OP_32: begin
                if (XLEN != 64) illegal = 1'b1;
            end
            OPCODE_SYSTEM: begin
`ifdef IMMGEN_CSR_ZIMM_EN
                // funct3[2] selects the immediate CSR forms
                if (inst[14]) begin
                    fmt   = FMT_Z;
                    imm32 = {27'b0, inst[19:15]};
                end else begin
                    fmt   = FMT_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
`endif
            end
            default: illegal = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
            fmt     = FMT_NONE;
            imm32   = '0;
        end
    end

    // signed cast sign-extends to XLEN
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a two-entry skid buffer, flush and a
// saturating illegal counter. Optional macro IMMGEN_CSR_ZIMM_EN (see imm_decode).
module imm_gen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    imm_gen_pipe_if.slave    bus,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_ill;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst    (bus.in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    logic            out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
    imm_fmt_e        out_fmt_q, out_fmt_d, skid_fmt_q, skid_fmt_d;
    logic            out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
    logic [31:0]     out_inst_q, out_inst_d, skid_inst_q, skid_inst_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            accept, drain;

    assign accept = bus.in_valid && !skid_vld_q;
    assign drain  = out_vld_q && bus.out_ready;

    always_comb begin
        out_vld_d   = out_vld_q;
        out_imm_d   = out_imm_q;
        out_fmt_d   = out_fmt_q;
        out_ill_d   = out_ill_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        skid_vld_d  = skid_vld_q;
        skid_imm_d  = skid_imm_q;
        skid_fmt_d  = skid_fmt_q;
        skid_ill_d  = skid_ill_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        cnt_d       = cnt_q;

        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (drain && skid_vld_q) begin
            // in_ready is low while the skid is full, so no accept can collide here
            out_imm_d  = skid_imm_q;
            out_fmt_d  = skid_fmt_q;
            out_ill_d  = skid_ill_q;
            out_inst_d = skid_inst_q;
            out_pc_d   = skid_pc_q;
            skid_vld_d = 1'b0;
        end else if (accept && (!out_vld_q || drain)) begin
            out_vld_d  = 1'b1;
            out_imm_d  = dec_imm;
            out_fmt_d  = dec_fmt;
            out_ill_d  = dec_ill;
            out_inst_d = bus.in_inst;
            out_pc_d   = bus.in_pc;
        end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_imm_d  = dec_imm;
            skid_fmt_d  = dec_fmt;
            skid_ill_d  = dec_ill;
            skid_inst_d = bus.in_inst;
            skid_pc_d   = bus.in_pc;
        end else if (drain) begin
            out_vld_d = 1'b0;
        end

        // counts completed handshakes, including one in a flush cycle
        if (drain && out_ill_q && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q   <= 1'b0;
            out_imm_q   <= '0;
            out_fmt_q   <= FMT_NONE;
            out_ill_q   <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
            skid_vld_q  <= 1'b0;
            skid_imm_q  <= '0;
            skid_fmt_q  <= FMT_NONE;
            skid_ill_q  <= 1'b0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            cnt_q       <= '0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_imm_q   <= out_imm_d;
            out_fmt_q   <= out_fmt_d;
            out_ill_q   <= out_ill_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            skid_vld_q  <= skid_vld_d;
            skid_imm_q  <= skid_imm_d;
            skid_fmt_q  <= skid_fmt_d;
            skid_ill_q  <= skid_ill_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready    = !skid_vld_q;
    assign bus.out_valid   = out_vld_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_fmt     = out_fmt_q;
    assign bus.out_illegal = out_ill_q;
    assign bus.out_inst    = out_inst_q;
    assign bus.out_pc      = out_pc_q;
    assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench: an XLEN=32 (CNT_W=16) and an XLEN=64 (CNT_W=2) instance share one
// stimulus stream and are checked against an arithmetic decode model and a depth-2 FIFO model.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [15:0] cnt32;
    logic [1:0]  cnt64;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) if32 ();
    imm_gen_pipe_if #(.XLEN(64)) if64 ();

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .bus(if32), .illegal_cnt(cnt32));
    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .bus(if64), .illegal_cnt(cnt64));

    typedef struct {
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [2:0]  fmt64, fmt32;
        logic        ill64, ill32;
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    exp_t q[$];
    int   m_cnt32, m_cnt64;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input longint val, input int bits);
        if (val >= (64'sd1 <<< (bits - 1))) return val - (64'sd1 <<< bits);
        return val;
    endfunction

    // Decode reference: immediates built from the field values by arithmetic.
    task automatic model(input logic [31:0] i, input bit x64,
                         output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
        longint v;
        v = 0; fmt = 3'd5; ill = 1'b0;
        if (i[1:0] != 2'b11) ill = 1'b1;
        else case (i[6:2])
            5'b00000, 5'b00100, 5'b11001: begin fmt = 3'd0; v = sx(longint'(i[31:20]), 12); end
            5'b00110: if (x64) begin fmt = 3'd0; v = sx(longint'(i[31:20]), 12); end else ill = 1'b1;
            5'b01000: begin fmt = 3'd1; v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12); end
            5'b11000: begin
                fmt = 3'd2;
                v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                       longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
            end
            5'b01101, 5'b00101: begin fmt = 3'd3; v = sx(longint'(i[31:12]), 20) * 4096; end
            5'b11011: begin
                fmt = 3'd4;
                v = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
                       longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
            end
            5'b01100: ;
            5'b01110: if (!x64) ill = 1'b1;
            5'b11100: begin
`ifdef IMMGEN_CSR_ZIMM_EN
                if (i[14]) begin fmt = 3'd6; v = longint'(i[19:15]); end
                else begin fmt = 3'd0; v = sx(longint'(i[31:20]), 12); end
`endif
            end
            default: ill = 1'b1;
        endcase
        imm = v;
    endtask

    task automatic check_outputs();
        chk("in_ready32",  64'(if32.in_ready),  64'(q.size() < 2));
        chk("in_ready64",  64'(if64.in_ready),  64'(q.size() < 2));
        chk("out_valid32", 64'(if32.out_valid), 64'(q.size() > 0));
        chk("out_valid64", 64'(if64.out_valid), 64'(q.size() > 0));
        chk("cnt32", 64'(cnt32), 64'(m_cnt32));
        chk("cnt64", 64'(cnt64), 64'(m_cnt64));
        if (q.size() > 0) begin
            chk("imm32",  64'(if32.out_imm),     64'(q[0].imm32));
            chk("imm64",  if64.out_imm,          q[0].imm64);
            chk("fmt32",  64'(if32.out_fmt),     64'(q[0].fmt32));
            chk("fmt64",  64'(if64.out_fmt),     64'(q[0].fmt64));
            chk("ill32",  64'(if32.out_illegal), 64'(q[0].ill32));
            chk("ill64",  64'(if64.out_illegal), 64'(q[0].ill64));
            chk("inst32", 64'(if32.out_inst),    64'(q[0].inst));
            chk("inst64", 64'(if64.out_inst),    64'(q[0].inst));
            chk("pc32",   64'(if32.out_pc),      64'(q[0].pc[31:0]));
            chk("pc64",   if64.out_pc,           q[0].pc);
        end
    endtask

    // One clock: check state, drive inputs, advance the models across the edge.
    task automatic step(input bit v, input logic [31:0] inst, input logic [63:0] pc,
                        input bit ordy, input bit fl, output bit acc);
        bit   drn;
        exp_t e;
        logic [63:0] imm32w;
        check_outputs();
        if32.in_valid = v;  if32.in_inst = inst; if32.in_pc = pc[31:0]; if32.out_ready = ordy;
        if64.in_valid = v;  if64.in_inst = inst; if64.in_pc = pc;       if64.out_ready = ordy;
        flush = fl;
        acc = v && !fl && (q.size() < 2);
        drn = ordy && (q.size() > 0);
        @(posedge clk);
        if (drn && q[0].ill32 && m_cnt32 < 65535) m_cnt32++;
        if (drn && q[0].ill64 && m_cnt64 < 3) m_cnt64++;
        if (fl) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                model(inst, 1'b1, e.imm64, e.fmt64, e.ill64);
                model(inst, 1'b0, imm32w, e.fmt32, e.ill32);
                e.imm32 = imm32w[31:0];
                e.inst  = inst;
                e.pc    = pc;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    logic [4:0]  ops [14];
    logic [31:0] stream [4];

    initial begin
        bit acc;
        int idx;
        logic [31:0] r;
        ops = '{5'b00000, 5'b00100, 5'b11001, 5'b00110, 5'b01000, 5'b11000, 5'b01101,
                5'b00101, 5'b11011, 5'b01100, 5'b01110, 5'b11100, 5'b10101, 5'b11111};
        stream = '{32'h00A00093, 32'h00112223, 32'hFE000EE3, 32'h0040006F};

        rst = 1'b1; flush = 1'b0;
        if32.in_valid = 0; if32.in_inst = 0; if32.in_pc = 0; if32.out_ready = 0;
        if64.in_valid = 0; if64.in_inst = 0; if64.in_pc = 0; if64.out_ready = 0;
        m_cnt32 = 0; m_cnt64 = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_imm", 64'(if32.out_imm), 64'd0);
        chk("rst_fmt", 64'(if64.out_fmt), 64'd5);
        chk("rst_ill", 64'(if64.out_illegal), 64'd0);
        chk("rst_inst", 64'(if32.out_inst), 64'd0);
        chk("rst_pc", if64.out_pc, 64'd0);
        rst = 1'b0;

        step(1, 32'hFFF00093, 64'h1000, 1, 0, acc);
        chk("addi_imm", 64'(if32.out_imm), 64'hFFFFFFFF);
        chk("addi_fmt", 64'(if32.out_fmt), 64'd0);
        step(1, 32'hFE000EE3, 64'h1004, 1, 0, acc);
        chk("beq_imm", if64.out_imm, 64'hFFFFFFFFFFFFFFFC);
        chk("beq_fmt", 64'(if64.out_fmt), 64'd2);
        step(1, 32'h80000037, 64'h1008, 1, 0, acc);
        chk("lui_imm", if64.out_imm, 64'hFFFFFFFF80000000);
        step(1, 32'h7C1FD073, 64'h100C, 1, 0, acc);
`ifdef IMMGEN_CSR_ZIMM_EN
        chk("csr_fmt", 64'(if64.out_fmt), 64'd6);
        chk("csr_imm", if64.out_imm, 64'd31);
`else
        chk("csr_fmt", 64'(if64.out_fmt), 64'd5);
        chk("csr_imm", if64.out_imm, 64'd0);
`endif
        step(0, 32'h0, 64'h0, 1, 0, acc);

        // four-entry stream with a two-cycle consumer stall
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            step(idx < 4, stream[idx % 4], 64'(32'h2000 + idx * 4), !(c == 1 || c == 2), 0, acc);
            if (acc) idx++;
        end
        chk("stream_accepted", 64'(idx), 64'd4);

        // flush with both entries full and an input offered
        step(1, 32'h00500113, 64'h3000, 0, 0, acc);
        step(1, 32'h00600193, 64'h3004, 0, 0, acc);
        chk("full_in_ready", 64'(if32.in_ready), 64'd0);
        step(1, 32'h00700213, 64'h3008, 0, 1, acc);
        chk("flush_valid", 64'(if64.out_valid), 64'd0);
        chk("flush_ready", 64'(if64.in_ready), 64'd1);

        // five illegal handshakes: dut64 counter saturates at 3
        for (int k = 0; k < 5; k++) step(1, 32'h0, 64'(k), 1, 0, acc);
        step(0, 32'h0, 64'h0, 1, 0, acc);
        chk("sat_cnt64", 64'(cnt64), 64'd3);
        chk("cnt32_5", 64'(cnt32), 64'd5);

        for (int c = 0; c < 1500; c++) begin
            r = $urandom;
            if ($urandom_range(0, 15) == 0) r[1:0] = 2'($urandom);
            else begin r[6:2] = ops[$urandom_range(0, 13)]; r[1:0] = 2'b11; end
            step($urandom_range(0, 3) != 0, r, {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0, acc);
        end

        // asynchronous reset with both entries full
        step(1, 32'h00000013, 64'h4000, 0, 0, acc);
        step(1, 32'h00000013, 64'h4004, 0, 0, acc);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(if32.out_valid), 64'd0);
        chk("arst_ready", 64'(if64.in_ready), 64'd1);
        chk("arst_cnt", 64'(cnt32), 64'd0);
        q.delete(); m_cnt32 = 0; m_cnt64 = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step(1, 32'h00C00513 + 32'(k << 20), 64'(k), 1, 0, acc);
        step(0, 32'h0, 64'h0, 1, 0, acc);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
